// File: rtl/hazard_scoreboard_pkg.sv
// Shared scoreboard types: per-register entry state, issue request and writeback request.
// Field widths are upper bounds; narrower top-level parameters are zero-extended into them.
package pipes;

  localparam int unsigned SB_RD_W  = 8;
  localparam int unsigned SB_ID_W  = 16;
  localparam int unsigned SB_LAT_W = 16;

  typedef struct packed {
    logic                busy;
    logic [SB_ID_W-1:0]  tag;
    logic [SB_LAT_W-1:0] cnt;
  } sb_entry_t;

  typedef struct packed {
    logic                valid;
    logic [SB_RD_W-1:0]  rd;
    logic [SB_ID_W-1:0]  id;
    logic [SB_LAT_W-1:0] lat;
  } sb_issue_t;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic [SB_ID_W-1:0] id;
  } sb_wb_t;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: busy/tag/cnt flops, update priority reset > issue > writeback > decrement.
// With SB_FWD_EN undefined the latency counter is held at zero and optimises away.
module sb_entry
  import pipes::*;
#(
  parameter int unsigned IDX = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  sb_issue_t issue,
  input  sb_wb_t    wb,
  output sb_entry_t ent
);

  sb_entry_t ent_q, ent_d;
  logic      issue_hit, wb_hit;

  always_comb begin
    issue_hit = issue.valid && (issue.rd == SB_RD_W'(IDX));
    // A writeback carrying a stale tag belongs to an overwritten writer and is ignored.
    wb_hit    = wb.valid && (wb.rd == SB_RD_W'(IDX)) && ent_q.busy && (ent_q.tag == wb.id);
    ent_d     = ent_q;
    if (issue_hit) begin
      ent_d.busy = 1'b1;
      ent_d.tag  = issue.id;
      ent_d.cnt  = issue.lat;
    end else if (wb_hit) begin
      ent_d.busy = 1'b0;
    end else if (ent_q.busy && (ent_q.cnt != '0)) begin
      ent_d.cnt = ent_q.cnt - 1'b1;
    end
`ifndef SB_FWD_EN
    ent_d.cnt = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent = ent_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for hazard detection: per-source stall/forward decisions and busy count.
// Define SB_FWD_EN to enable latency-based forwarding; otherwise busy sources block until writeback.
module hazard_scoreboard
  import pipes::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned LAT_W = 4,
  parameter int unsigned ID_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [$clog2(NREG)-1:0]   issue_rd,
  input  logic [ID_W-1:0]           issue_id,
  input  logic [LAT_W-1:0]          issue_lat,
  input  logic                      flush,
  input  logic                      wb_valid,
  input  logic [$clog2(NREG)-1:0]   wb_rd,
  input  logic [ID_W-1:0]           wb_id,
  input  logic [NSRC*$clog2(NREG)-1:0] src_rs,
  output logic [NSRC-1:0]           src_fwd,
  output logic                      stall,
  output logic [$clog2(NREG+1)-1:0] busy_cnt
);

  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned CW = $clog2(NREG + 1);

  sb_issue_t       issue;
  sb_wb_t          wb;
  sb_entry_t       ents [NREG];
  logic [NSRC-1:0] fwd, blk;

  assign issue.valid = issue_valid && !flush && (issue_rd != '0);
  assign issue.rd    = SB_RD_W'(issue_rd);
  assign issue.id    = SB_ID_W'(issue_id);
  assign issue.lat   = SB_LAT_W'(issue_lat);
  assign wb.valid    = wb_valid;
  assign wb.rd       = SB_RD_W'(wb_rd);
  assign wb.id       = SB_ID_W'(wb_id);

  assign ents[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry #(
      .IDX(r)
    ) u_ent (
      .clk  (clk),
      .reset(reset),
      .issue(issue),
      .wb   (wb),
      .ent  (ents[r])
    );
  end

  always_comb begin
    logic [RW-1:0] rs;
    sb_entry_t     e;
    logic          rdy;
    fwd = '0;
    blk = '0;
    for (int s = 0; s < NSRC; s++) begin
      rs  = src_rs[s*RW +: RW];
      e   = ents[rs];
      // Same-cycle writeback with the owning tag is written through the regfile.
      rdy = (rs == '0) || !e.busy ||
            (wb_valid && (wb_rd == rs) && (e.tag == SB_ID_W'(wb_id)));
`ifdef SB_FWD_EN
      fwd[s] = !rdy && (e.cnt == '0);
`else
      fwd[s] = 1'b0;
`endif
      blk[s] = !rdy && !fwd[s];
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_cnt = busy_cnt + CW'(ents[r].busy);
    end
  end

  assign src_fwd = fwd;
  assign stall   = |blk;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard; expectations follow SB_FWD_EN when defined.
module tb_hazard_scoreboard;

`ifdef SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_rd;
  logic [3:0] issue_id;
  logic [3:0] issue_lat;
  logic       flush;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic [3:0] wb_id;
  logic [9:0] src_rs;
  logic [1:0] src_fwd;
  logic       stall;
  logic [5:0] busy_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_id   (issue_id),
    .issue_lat  (issue_lat),
    .flush      (flush),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_id      (wb_id),
    .src_rs     (src_rs),
    .src_fwd    (src_fwd),
    .stall      (stall),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  // fwd_f/stall_f: expectations with forwarding; stall_n: without (src_fwd then always 0).
  typedef struct {
    logic       iv;
    logic [4:0] ird;
    logic [3:0] iid;
    logic [3:0] ilat;
    logic       fl;
    logic       wv;
    logic [4:0] wrd;
    logic [3:0] wid;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] fwd_f;
    logic       stall_f;
    logic       stall_n;
    logic [5:0] bc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic [3:0] iid,
                       input logic [3:0] ilat, input logic fl, input logic wv,
                       input logic [4:0] wrd, input logic [3:0] wid,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    @(posedge clk);
    #1;
    issue_valid = iv;
    issue_rd    = ird;
    issue_id    = iid;
    issue_lat   = ilat;
    flush       = fl;
    wb_valid    = wv;
    wb_rd       = wrd;
    wb_id       = wid;
    src_rs      = {rs1, rs0};
  endtask

  task automatic check_outs(input string tag, input logic [1:0] efwd, input logic estall,
                            input logic [5:0] ebc);
    @(negedge clk);
    check({tag, ".src_fwd"}, 32'(src_fwd), 32'(efwd));
    check({tag, ".stall"}, 32'(stall), 32'(estall));
    check({tag, ".busy_cnt"}, 32'(busy_cnt), 32'(ebc));
  endtask

  initial begin
    //             iv ird iid lat fl wv wrd wid rs0 rs1 fwd_f  st_f  st_n  bc
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 2'b00, 1'b0, 1'b0, 0}); // 0 after reset
    vecs.push_back('{1, 5, 3, 2, 0, 0, 0, 0, 5, 6, 2'b00, 1'b0, 1'b0, 0}); // 1 issue rd5 lat2
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 2'b00, 1'b1, 1'b1, 1}); // 2 t+1
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 2'b00, 1'b1, 1'b1, 1}); // 3 t+2
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 2'b01, 1'b0, 1'b1, 1}); // 4 t+3 fwd
    vecs.push_back('{0, 0, 0, 0, 0, 1, 5, 3, 5, 6, 2'b00, 1'b0, 1'b0, 1}); // 5 wb bypass
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 5, 6, 2'b00, 1'b0, 1'b0, 0}); // 6 idle
    vecs.push_back('{1, 7, 1, 0, 0, 0, 0, 0, 7, 0, 2'b00, 1'b0, 1'b0, 0}); // 7 WAW first
    vecs.push_back('{1, 7, 2, 3, 0, 0, 0, 0, 7, 0, 2'b01, 1'b0, 1'b1, 1}); // 8 WAW second
    vecs.push_back('{0, 0, 0, 0, 0, 1, 7, 1, 7, 0, 2'b00, 1'b1, 1'b1, 1}); // 9 stale wb
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 1'b1, 1'b1, 1}); // 10
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 1'b1, 1'b1, 1}); // 11
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 2'b01, 1'b0, 1'b1, 1}); // 12 cnt expired
    vecs.push_back('{0, 0, 0, 0, 0, 1, 7, 2, 7, 0, 2'b00, 1'b0, 1'b0, 1}); // 13 owner wb
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 2'b00, 1'b0, 1'b0, 0}); // 14 cleared
    vecs.push_back('{1, 9, 1, 0, 0, 0, 0, 0, 9, 0, 2'b00, 1'b0, 1'b0, 0}); // 15 issue rd9 id1
    vecs.push_back('{1, 9, 4, 1, 0, 1, 9, 1, 9, 0, 2'b00, 1'b0, 1'b0, 1}); // 16 issue+wb same
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 2'b00, 1'b1, 1'b1, 1}); // 17 tag4 owns
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 2'b10, 1'b0, 1'b1, 1}); // 18 fwd on src1
    vecs.push_back('{0, 0, 0, 0, 0, 1, 9, 4, 0, 9, 2'b00, 1'b0, 1'b0, 1}); // 19 wb id4
    vecs.push_back('{1, 10, 5, 0, 1, 0, 0, 0, 10, 0, 2'b00, 1'b0, 1'b0, 0}); // 20 flushed
    vecs.push_back('{1, 0, 6, 0, 0, 0, 0, 0, 10, 0, 2'b00, 1'b0, 1'b0, 0}); // 21 rd0 issue
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 2'b00, 1'b0, 1'b0, 0}); // 22 nothing busy

    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_id    = '0;
    issue_lat   = '0;
    flush       = 1'b0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_id       = '0;
    src_rs      = {5'd6, 5'd5};
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outs("reset", 2'b00, 1'b0, 6'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ird, vecs[i].iid, vecs[i].ilat, vecs[i].fl,
            vecs[i].wv, vecs[i].wrd, vecs[i].wid, vecs[i].rs0, vecs[i].rs1);
      check_outs($sformatf("vec%0d", i), FWD ? vecs[i].fwd_f : 2'b00,
                 FWD ? vecs[i].stall_f : vecs[i].stall_n, vecs[i].bc);
    end

    // Counter saturates at zero: long after expiry the source still forwards (or blocks).
    drive(1, 12, 7, 1, 0, 0, 0, 0, 12, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 12, 0);
    repeat (20) @(posedge clk);
    check_outs("saturate", FWD ? 2'b01 : 2'b00, FWD ? 1'b0 : 1'b1, 6'd1);

    // Mid-operation reset beats a concurrent issue and drops every entry.
    drive(1, 3, 1, 5, 0, 0, 0, 0, 3, 4);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    check_outs("pre_reset", 2'b00, 1'b1, 6'd2);
    drive(1, 4, 2, 0, 0, 0, 0, 0, 3, 4);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 4);
    reset = 1'b0;
    check_outs("post_reset", 2'b00, 1'b0, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
